cgra_im_loader: RTL and testbench
=================================

CGRA_IM_LOADER -- requirements
Module: cgra_im_loader

Interface
REQ-001 Parameter I_WIDTH, default 12, instruction-decoder word width.
REQ-002 Parameter I_IMM_WIDTH, default 33, immediate-unit word width; legal range 33..64.
REQ-003 Parameter IM_MEM_ADDR_WIDTH, default 8, instruction-memory address width.
REQ-004 Parameter NUM_ID, default 10, number of decoder memories; target indices 0..NUM_ID-1.
REQ-005 Parameter NUM_IMM, default 4, number of immediate memories; target indices NUM_ID..NUM_ID+NUM_IMM-1.
REQ-006 iClk  input  1  single clock, rising edge.
REQ-007 iReset_n  input  1  reset, asynchronous, active-low.
REQ-008 iLoad_Data  input  32  load-stream word.
REQ-009 iLoad_Valid  input  1  iLoad_Data valid.
REQ-010 oLoad_Ready  output  1  loader accepts word; transfer = iLoad_Valid & oLoad_Ready at rising edge.
REQ-011 oIM_WriteEnable  output  NUM_ID+NUM_IMM  one-hot write strobe, bit = target index.
REQ-012 oIM_WriteAddress  output  IM_MEM_ADDR_WIDTH  shared write address.
REQ-013 oIM_WriteData  output  I_WIDTH  decoder write data.
REQ-014 oIM_WriteData_IMM  output  I_IMM_WIDTH  immediate write data.
REQ-015 oBusy  output  1  high in every state except IDLE.
REQ-016 oDone  output  1  one-cycle pulse when a block completes.
REQ-017 oError  output  1  sticky error flag.

Function
REQ-018 Block format: H0 = {count[31:16], rsvd[15:8], target[7:0]}; H1 = start address (low IM_MEM_ADDR_WIDTH bits used); then count payload instructions.
REQ-019 Decoder targets: one payload word per instruction, data = word[I_WIDTH-1:0].
REQ-020 Immediate targets: two words per instruction, LO then HI; data = {HI[I_IMM_WIDTH-33:0], LO}.
REQ-021 States: IDLE, HDR1, DATA_LO, DATA_HI, DRAIN (+CHECK, REQ-034); oLoad_Ready = 1 in all states.
REQ-022 IDLE: accept H0 -> HDR1; latch target and count.
REQ-023 HDR1: accept H1 -> latch address; count=0 -> IDLE and oDone pulse; invalid target (>= NUM_ID+NUM_IMM) -> DRAIN and set oError; else -> DATA_LO.
REQ-024 DATA_LO: accept word; decoder target -> issue write; immediate target -> latch LO, go to DATA_HI.
REQ-025 DATA_HI: accept word -> issue write, return to DATA_LO.
REQ-026 Write issue: registered; in the cycle after the final word of an instruction is accepted, exactly one oIM_WriteEnable bit is high for exactly one cycle, with address and data valid in that same cycle.
REQ-027 After each write: address increments modulo 2^IM_MEM_ADDR_WIDTH (wrap 255 -> 0 at default); remaining count decrements.
REQ-028 Last write of a block -> IDLE; oDone pulses in the same cycle as that write.
REQ-029 DRAIN: consume count words (2*count for indices in the immediate range cannot occur; invalid targets count single words), no writes, then IDLE and oDone.
REQ-030 iLoad_Valid low: state, address and count hold; no write issued.
REQ-031 oIM_WriteData and oIM_WriteData_IMM hold their last values when no write strobe is active.
REQ-032 oError is cleared only by reset.

Reset
REQ-033 Asserting iReset_n low, including mid-block, forces IDLE, aborts the block with no further writes, and clears all outputs to 0 (oLoad_Ready = 1 after release).

Configuration
REQ-034 With macro CGRA_IM_LOADER_CHECKSUM_EN defined: the loader keeps a running XOR of all payload words; after the last payload word it enters CHECK and accepts one trailing word; a mismatch sets oError; oDone pulses on acceptance of the checksum word; writes already issued are not revoked. Without the macro: there is no CHECK state and no trailing word.

Verification
REQ-035 Decoder load: H0=0x0003_0004, H1=0x10, payload 0xA01,0xA02,0xA03 -> writes to enable bit 4 at addresses 0x10,0x11,0x12 with data 0xA01..0xA03; oDone coincident with third write.
REQ-036 Immediate load: target 11, count 1, address 0x05, LO=0xDEADBEEF, HI=0x1 -> one write on enable bit 11, oIM_WriteData_IMM=0x1_DEADBEEF, address 0x05.
REQ-037 Wrap and stall: target 0, start address 0xFF, count 2, iLoad_Valid toggled every other cycle -> writes at addresses 0xFF then 0x00, one write per accepted word.
REQ-038 Invalid target 20, count 2 -> two words drained, no write strobe, oError=1 held, oDone pulsed, next valid block loads normally.
REQ-039 Reset mid-block after 1 of 3 words -> no further writes, oBusy=0; a new H0 is accepted as header.
REQ-040 With CGRA_IM_LOADER_CHECKSUM_EN defined: payload 0x1, 0x2 with checksum 0x3 -> oError=0; with checksum 0x4 -> oError=1.

Source files
------------

// File: rtl/cgra_im_loader.sv
// CGRA instruction-memory loader: parses header/payload blocks from a 32-bit stream
// and issues one registered write per instruction. Optional CGRA_IM_LOADER_CHECKSUM_EN adds a trailing XOR check word.
module cgra_im_loader #(
   parameter int I_WIDTH           = 12,
   parameter int I_IMM_WIDTH       = 33,
   parameter int IM_MEM_ADDR_WIDTH = 8,
   parameter int NUM_ID            = 10,
   parameter int NUM_IMM           = 4
) (
   input  logic                           iClk,
   input  logic                           iReset_n,
   input  logic [31:0]                    iLoad_Data,
   input  logic                           iLoad_Valid,
   output logic                           oLoad_Ready,
   output logic [NUM_ID+NUM_IMM-1:0]      oIM_WriteEnable,
   output logic [IM_MEM_ADDR_WIDTH-1:0]   oIM_WriteAddress,
   output logic [I_WIDTH-1:0]             oIM_WriteData,
   output logic [I_IMM_WIDTH-1:0]         oIM_WriteData_IMM,
   output logic                           oBusy,
   output logic                           oDone,
   output logic                           oError
);
   localparam int NW = NUM_ID + NUM_IMM;
   localparam int AW = IM_MEM_ADDR_WIDTH;
   localparam logic [7:0] TGT_IMM_LO = 8'(NUM_ID);
   localparam logic [7:0] TGT_END    = 8'(NW);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR1,
      S_DATA_LO,
      S_DATA_HI,
      S_DRAIN
`ifdef CGRA_IM_LOADER_CHECKSUM_EN
      , S_CHECK
`endif
   } state_t;

   state_t            r_state, w_next;
   logic [7:0]        r_target;
   logic [15:0]       r_count;
   logic [AW-1:0]     r_addr;
   logic [31:0]       r_lo;
   logic              r_ready;
   logic [NW-1:0]     r_we;
   logic [AW-1:0]     r_waddr;
   logic [I_WIDTH-1:0]     r_wdata;
   logic [I_IMM_WIDTH-1:0] r_wdata_imm;
   logic              r_done;
   logic              r_error;
`ifdef CGRA_IM_LOADER_CHECKSUM_EN
   logic [31:0]       r_csum;
`endif

   logic              w_acc, w_imm_tgt, w_bad_tgt, w_last;
   logic              w_issue, w_done, w_set_err, w_payload, w_block_end;
   logic [NW-1:0]     w_onehot;

   assign w_acc     = iLoad_Valid & r_ready;
   assign w_imm_tgt = (r_target >= TGT_IMM_LO) && (r_target < TGT_END);
   assign w_bad_tgt = (r_target >= TGT_END);
   assign w_last    = (r_count == 16'd1);
   assign w_onehot  = {{(NW-1){1'b0}}, 1'b1} << r_target;

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) r_state <= S_IDLE;
      else           r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_issue     = 1'b0;
      w_done      = 1'b0;
      w_set_err   = 1'b0;
      w_payload   = 1'b0;
      w_block_end = 1'b0;
      case (r_state)
         S_IDLE: if (w_acc) w_next = S_HDR1;
         S_HDR1: if (w_acc) begin
            if (r_count == 16'd0) begin
               w_next = S_IDLE;
               w_done = 1'b1;
            end else if (w_bad_tgt) begin
               w_next    = S_DRAIN;
               w_set_err = 1'b1;
            end else begin
               w_next = S_DATA_LO;
            end
         end
         S_DATA_LO: if (w_acc) begin
            w_payload = 1'b1;
            if (w_imm_tgt) begin
               w_next = S_DATA_HI;
            end else begin
               w_issue     = 1'b1;
               w_block_end = w_last;
            end
         end
         S_DATA_HI: if (w_acc) begin
            w_payload   = 1'b1;
            w_issue     = 1'b1;
            w_next      = S_DATA_LO;
            w_block_end = w_last;
         end
         // Invalid targets consume single words and never write.
         S_DRAIN: if (w_acc) begin
            w_payload   = 1'b1;
            w_block_end = w_last;
         end
`ifdef CGRA_IM_LOADER_CHECKSUM_EN
         S_CHECK: if (w_acc) begin
            w_next    = S_IDLE;
            w_done    = 1'b1;
            w_set_err = (iLoad_Data != r_csum);
         end
`endif
         default: w_next = S_IDLE;
      endcase
      if (w_block_end) begin
`ifdef CGRA_IM_LOADER_CHECKSUM_EN
         w_next = S_CHECK;
`else
         w_next = S_IDLE;
         w_done = 1'b1;
`endif
      end
   end

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         r_target    <= '0;
         r_count     <= '0;
         r_addr      <= '0;
         r_lo        <= '0;
         r_ready     <= 1'b0;
         r_we        <= '0;
         r_waddr     <= '0;
         r_wdata     <= '0;
         r_wdata_imm <= '0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
`ifdef CGRA_IM_LOADER_CHECKSUM_EN
         r_csum      <= '0;
`endif
      end else begin
         r_ready <= 1'b1;
         r_done  <= w_done;
         r_error <= r_error | w_set_err;
         r_we    <= '0;
         if (r_state == S_IDLE && w_acc) begin
            r_target <= iLoad_Data[7:0];
            r_count  <= iLoad_Data[31:16];
`ifdef CGRA_IM_LOADER_CHECKSUM_EN
            r_csum   <= '0;
`endif
         end
         if (r_state == S_HDR1 && w_acc) r_addr <= iLoad_Data[AW-1:0];
         if (r_state == S_DATA_LO && w_acc && w_imm_tgt) r_lo <= iLoad_Data;
         if (r_state == S_DRAIN && w_acc) r_count <= r_count - 16'd1;
`ifdef CGRA_IM_LOADER_CHECKSUM_EN
         if (w_payload) r_csum <= r_csum ^ iLoad_Data;
`endif
         if (w_issue) begin
            r_we    <= w_onehot;
            r_waddr <= r_addr;
            r_addr  <= r_addr + AW'(1);
            r_count <= r_count - 16'd1;
            // Only the data port matching the target class is updated; the other holds.
            if (w_imm_tgt) r_wdata_imm <= {iLoad_Data[I_IMM_WIDTH-33:0], r_lo};
            else           r_wdata     <= iLoad_Data[I_WIDTH-1:0];
         end
      end
   end

   assign oLoad_Ready       = r_ready;
   assign oIM_WriteEnable   = r_we;
   assign oIM_WriteAddress  = r_waddr;
   assign oIM_WriteData     = r_wdata;
   assign oIM_WriteData_IMM = r_wdata_imm;
   assign oBusy             = (r_state != S_IDLE);
   assign oDone             = r_done;
   assign oError            = r_error;
endmodule

// File: tb/tb_cgra_im_loader.sv
// Directed self-checking bench for cgra_im_loader (default build; checksum scenario
// runs only when CGRA_IM_LOADER_CHECKSUM_EN is defined).
module tb_cgra_im_loader;
   localparam int NW = 14;

   logic        iClk = 1'b0;
   logic        iReset_n = 1'b0;
   logic [31:0] iLoad_Data = '0;
   logic        iLoad_Valid = 1'b0;
   logic        oLoad_Ready;
   logic [NW-1:0] oIM_WriteEnable;
   logic [7:0]  oIM_WriteAddress;
   logic [11:0] oIM_WriteData;
   logic [32:0] oIM_WriteData_IMM;
   logic        oBusy, oDone, oError;

   cgra_im_loader dut (
      .iClk(iClk), .iReset_n(iReset_n), .iLoad_Data(iLoad_Data), .iLoad_Valid(iLoad_Valid),
      .oLoad_Ready(oLoad_Ready), .oIM_WriteEnable(oIM_WriteEnable),
      .oIM_WriteAddress(oIM_WriteAddress), .oIM_WriteData(oIM_WriteData),
      .oIM_WriteData_IMM(oIM_WriteData_IMM), .oBusy(oBusy), .oDone(oDone), .oError(oError)
   );

   always #5 iClk = ~iClk;

   int total = 0;
   int bad = 0;

   // Write/done log sampled mid-cycle; tasks index it relative to a snapshot.
   int wr_n = 0;
   int done_n = 0;
   logic [NW-1:0] log_we   [64];
   logic [7:0]    log_addr [64];
   logic [11:0]   log_d    [64];
   logic [32:0]   log_imm  [64];
   logic          log_done [64];

   always @(negedge iClk) begin
      if (|oIM_WriteEnable) begin
         if (wr_n < 64) begin
            log_we[wr_n]   = oIM_WriteEnable;
            log_addr[wr_n] = oIM_WriteAddress;
            log_d[wr_n]    = oIM_WriteData;
            log_imm[wr_n]  = oIM_WriteData_IMM;
            log_done[wr_n] = oDone;
         end
         wr_n++;
      end
      if (oDone) done_n++;
   end

   task automatic send(input logic [31:0] w);
      iLoad_Data  = w;
      iLoad_Valid = 1'b1;
      @(posedge iClk); #1;
      iLoad_Valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge iClk); #1; end
   endtask

   task automatic test_reset;
      #12;
      total++; if (oLoad_Ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b exp=0", oLoad_Ready); end
      total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", oBusy); end
      total++; if (oDone !== 1'b0 || oError !== 1'b0) begin bad++; $display("FAIL rst_flags done=%0b err=%0b exp=0", oDone, oError); end
      total++; if (oIM_WriteEnable !== '0 || oIM_WriteAddress !== '0) begin bad++; $display("FAIL rst_we we=%h addr=%h exp=0", oIM_WriteEnable, oIM_WriteAddress); end
      total++; if (oIM_WriteData !== '0 || oIM_WriteData_IMM !== '0) begin bad++; $display("FAIL rst_data d=%h imm=%h exp=0", oIM_WriteData, oIM_WriteData_IMM); end
      @(negedge iClk); iReset_n = 1'b1;
      @(posedge iClk); #1;
      total++; if (oLoad_Ready !== 1'b1) begin bad++; $display("FAIL rel_ready got=%0b exp=1", oLoad_Ready); end
   endtask

   task automatic test_decoder;
      int w0, d0;
      logic [NW-1:0] e;
      w0 = wr_n; d0 = done_n;
      e = 1; e = e << 4;
      send(32'h0003_0004); send(32'h0000_0010); send(32'h0000_0A01);
      total++; if (oBusy !== 1'b1) begin bad++; $display("FAIL dec_busy got=%0b exp=1", oBusy); end
      send(32'h0000_0A02); send(32'h0000_0A03); idle(2);
      total++; if (wr_n - w0 !== 3) begin bad++; $display("FAIL dec_nwr got=%0d exp=3", wr_n - w0); end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (log_we[w0+i] !== e || log_addr[w0+i] !== 8'(8'h10 + i) || log_d[w0+i] !== 12'(12'hA01 + i)
             || log_done[w0+i] !== (i == 2)) begin
            bad++;
            $display("FAIL dec_wr%0d we=%h addr=%h d=%h done=%0b exp we=%h addr=%h d=%h done=%0b", i,
                     log_we[w0+i], log_addr[w0+i], log_d[w0+i], log_done[w0+i], e, 8'(8'h10 + i), 12'(12'hA01 + i), (i == 2));
         end
      end
      total++; if (done_n - d0 !== 1) begin bad++; $display("FAIL dec_done got=%0d exp=1", done_n - d0); end
      total++; if (oIM_WriteEnable !== '0 || oBusy !== 1'b0 || oError !== 1'b0) begin bad++; $display("FAIL dec_after we=%h busy=%0b err=%0b exp 0", oIM_WriteEnable, oBusy, oError); end
      total++; if (oIM_WriteData !== 12'hA03) begin bad++; $display("FAIL dec_hold got=%h exp=a03", oIM_WriteData); end
   endtask

   task automatic test_immediate;
      int w0;
      logic [NW-1:0] e;
      w0 = wr_n;
      e = 1; e = e << 11;
      send(32'h0001_000B); send(32'h0000_0005); send(32'hDEAD_BEEF);
      total++; if (oIM_WriteEnable !== '0) begin bad++; $display("FAIL imm_nolo got=%h exp=0", oIM_WriteEnable); end
      send(32'h0000_0001); idle(2);
      total++; if (wr_n - w0 !== 1) begin bad++; $display("FAIL imm_nwr got=%0d exp=1", wr_n - w0); end
      total++;
      if (log_we[w0] !== e || log_addr[w0] !== 8'h05 || log_imm[w0] !== 33'h1_DEAD_BEEF || log_done[w0] !== 1'b1) begin
         bad++;
         $display("FAIL imm_wr we=%h addr=%h imm=%h done=%0b exp we=%h addr=05 imm=1deadbeef done=1",
                  log_we[w0], log_addr[w0], log_imm[w0], log_done[w0], e);
      end
      total++; if (oIM_WriteData !== 12'hA03) begin bad++; $display("FAIL imm_dhold got=%h exp=a03", oIM_WriteData); end
   endtask

   task automatic test_wrap_stall;
      int w0;
      logic [NW-1:0] e;
      w0 = wr_n;
      e = 1;
      send(32'h0002_0000); idle(1); send(32'h0000_00FF); idle(1); send(32'h0000_0111); idle(1);
      total++; if (oBusy !== 1'b1 || oIM_WriteEnable !== '0) begin bad++; $display("FAIL wrap_stall busy=%0b we=%h exp busy=1 we=0", oBusy, oIM_WriteEnable); end
      send(32'h0000_0222); idle(2);
      total++; if (wr_n - w0 !== 2) begin bad++; $display("FAIL wrap_nwr got=%0d exp=2", wr_n - w0); end
      total++;
      if (log_we[w0] !== e || log_addr[w0] !== 8'hFF || log_d[w0] !== 12'h111) begin
         bad++; $display("FAIL wrap_wr0 we=%h addr=%h d=%h exp we=%h addr=ff d=111", log_we[w0], log_addr[w0], log_d[w0], e);
      end
      total++;
      if (log_we[w0+1] !== e || log_addr[w0+1] !== 8'h00 || log_d[w0+1] !== 12'h222 || log_done[w0+1] !== 1'b1) begin
         bad++; $display("FAIL wrap_wr1 we=%h addr=%h d=%h done=%0b exp we=%h addr=00 d=222 done=1",
                         log_we[w0+1], log_addr[w0+1], log_d[w0+1], log_done[w0+1], e);
      end
   endtask

   task automatic test_invalid;
      int w0, d0;
      logic [NW-1:0] e;
      w0 = wr_n; d0 = done_n;
      send(32'h0002_0014); send(32'h0000_0000); send(32'h0000_0AAA);
      total++; if (oBusy !== 1'b1 || oError !== 1'b1) begin bad++; $display("FAIL inv_drain busy=%0b err=%0b exp 1 1", oBusy, oError); end
      send(32'h0000_0BBB); idle(2);
      total++; if (wr_n - w0 !== 0) begin bad++; $display("FAIL inv_nwr got=%0d exp=0", wr_n - w0); end
      total++; if (done_n - d0 !== 1 || oBusy !== 1'b0) begin bad++; $display("FAIL inv_done done=%0d busy=%0b exp 1 0", done_n - d0, oBusy); end
      w0 = wr_n;
      e = 1; e = e << 2;
      send(32'h0001_0002); send(32'h0000_0030); send(32'h0000_0123); idle(2);
      total++;
      if (wr_n - w0 !== 1 || log_we[w0] !== e || log_addr[w0] !== 8'h30 || log_d[w0] !== 12'h123) begin
         bad++; $display("FAIL inv_next n=%0d we=%h addr=%h d=%h exp n=1 we=%h addr=30 d=123",
                         wr_n - w0, log_we[w0], log_addr[w0], log_d[w0], e);
      end
      total++; if (oError !== 1'b1) begin bad++; $display("FAIL inv_sticky got=%0b exp=1", oError); end
   endtask

   task automatic test_zero_count;
      int w0, d0;
      w0 = wr_n; d0 = done_n;
      send(32'h0000_0003); send(32'h0000_0040); idle(2);
      total++; if (wr_n - w0 !== 0 || done_n - d0 !== 1 || oBusy !== 1'b0) begin
         bad++; $display("FAIL zero_cnt nwr=%0d done=%0d busy=%0b exp 0 1 0", wr_n - w0, done_n - d0, oBusy);
      end
   endtask

   task automatic test_reset_mid;
      int w0;
      logic [NW-1:0] e;
      w0 = wr_n;
      send(32'h0003_0001); send(32'h0000_0020); send(32'h0000_0055); idle(2);
      total++; if (wr_n - w0 !== 1) begin bad++; $display("FAIL rmid_pre got=%0d exp=1", wr_n - w0); end
      @(negedge iClk); iReset_n = 1'b0; #2;
      total++; if (oBusy !== 1'b0 || oError !== 1'b0 || oIM_WriteData !== '0) begin
         bad++; $display("FAIL rmid_rst busy=%0b err=%0b d=%h exp 0 0 0", oBusy, oError, oIM_WriteData);
      end
      @(negedge iClk); iReset_n = 1'b1;
      @(posedge iClk); #1;
      w0 = wr_n;
      e = 1; e = e << 1;
      send(32'h0001_0001); send(32'h0000_0060); send(32'h0000_0077); idle(2);
      total++;
      if (wr_n - w0 !== 1 || log_we[w0] !== e || log_addr[w0] !== 8'h60 || log_d[w0] !== 12'h077) begin
         bad++; $display("FAIL rmid_new n=%0d we=%h addr=%h d=%h exp n=1 we=%h addr=60 d=077",
                         wr_n - w0, log_we[w0], log_addr[w0], log_d[w0], e);
      end
   endtask

`ifdef CGRA_IM_LOADER_CHECKSUM_EN
   task automatic test_checksum;
      send(32'h0002_0001); send(32'h0000_0070); send(32'h1); send(32'h2); send(32'h3); idle(2);
      total++; if (oError !== 1'b0) begin bad++; $display("FAIL csum_ok got=%0b exp=0", oError); end
      send(32'h0002_0001); send(32'h0000_0070); send(32'h1); send(32'h2); send(32'h4); idle(2);
      total++; if (oError !== 1'b1) begin bad++; $display("FAIL csum_bad got=%0b exp=1", oError); end
   endtask
`endif

   initial begin
      test_reset;
      test_decoder;
      test_immediate;
      test_wrap_stall;
      test_invalid;
      test_zero_count;
      test_reset_mid;
`ifdef CGRA_IM_LOADER_CHECKSUM_EN
      test_checksum;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
